cmp_iter: RTL and testbench

Iterative, parametrised compare unit for the Beta datapath: successor to the flag-driven combinational comparator. It takes two WIDTH-bit operands directly instead of ALU flags and supports signed and unsigned EQ/LT/LE. It resolves the compare CHUNK bits per cycle, most significant chunk first, behind a valid/ready handshake. The result is a WIDTH-bit 0/1 word ready for the register-file writeback mux.

---
 rtl/cmp_iter.sv | 225 ++++++++++++++++++++++
 tb/tb_cmp_iter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_iter.sv
// cmp_iter: iterative signed/unsigned EQ/LT/LE comparator.
// Operands are resolved CHUNK bits per cycle, most significant chunk first,
// behind a valid/ready handshake. The result is a WIDTH-bit 0/1 word.
// Optional feature macro: CMP_EARLY_EXIT_EN (leave SCAN on the first
// differing chunk); when undefined the scan always walks all N chunks.
module cmp_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Only the five documented opcodes start a scan.
  function automatic logic op_legal(input logic [2:0] o);
    case (o)
      3'b000, 3'b001, 3'b010, 3'b101, 3'b110: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  endfunction

  // Map the final lt/eq pair onto the requested relation.
  function automatic logic rel_bit(input logic [2:0] o, input logic lt, input logic eq);
    case (o)
      3'b000:         rel_bit = eq;
      3'b001, 3'b101: rel_bit = lt;
      3'b010, 3'b110: rel_bit = lt | eq;
      default:        rel_bit = 1'b0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [KW-1:0]    k_q, k_d;
  logic             lt_q, lt_d, eq_q, eq_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;
`ifndef CMP_EARLY_EXIT_EN
  logic             found_q, found_d;
`endif

  logic [CHUNK-1:0] a_c, b_c;
  logic             diff_c, lt_c;
  logic             fin_lt, fin_eq;

  // Next-state and datapath computation for the compare FSM.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    k_d         = k_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifndef CMP_EARLY_EXIT_EN
    found_d     = found_q;
`endif
    a_c    = a_q[int'(k_q)*CHUNK +: CHUNK];
    b_c    = b_q[int'(k_q)*CHUNK +: CHUNK];
    diff_c = (a_c != b_c);
    lt_c   = (a_c < b_c);
    fin_lt = 1'b0;
    fin_eq = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d  = a;
          b_d  = b;
          op_d = op;
          // Offset-binary bias makes an unsigned compare yield signed order.
          if (!op[2]) begin
            a_d[WIDTH-1] = ~a[WIDTH-1];
            b_d[WIDTH-1] = ~b[WIDTH-1];
          end else begin
            a_d[WIDTH-1] = a[WIDTH-1];
            b_d[WIDTH-1] = b[WIDTH-1];
          end
          lt_d   = 1'b0;
          eq_d   = 1'b0;
          busy_d = 1'b1;
`ifndef CMP_EARLY_EXIT_EN
          found_d = 1'b0;
`endif
          if (op_legal(op)) begin
            k_d     = KW'(N - 1);
            state_d = SCAN;
          end else begin
            result_d    = {WIDTH{1'b0}};
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SCAN: begin
`ifdef CMP_EARLY_EXIT_EN
        if (diff_c) begin
          fin_lt = lt_c;
          fin_eq = 1'b0;
        end else begin
          fin_lt = 1'b0;
          fin_eq = 1'b1;
        end
        lt_d = fin_lt;
        eq_d = fin_eq;
        if (diff_c || (k_q == {KW{1'b0}})) begin
          result_d    = {{(WIDTH-1){1'b0}}, rel_bit(op_q, fin_lt, fin_eq)};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          k_d = k_q - KW'(1);
        end
`else
        // The first differing chunk wins; later chunks cannot overwrite it.
        if (found_q) begin
          fin_lt = lt_q;
          fin_eq = eq_q;
        end else if (diff_c) begin
          fin_lt = lt_c;
          fin_eq = 1'b0;
        end else begin
          fin_lt = 1'b0;
          fin_eq = 1'b1;
        end
        lt_d    = fin_lt;
        eq_d    = fin_eq;
        found_d = found_q | diff_c;
        if (k_q == {KW{1'b0}}) begin
          result_d    = {{(WIDTH-1){1'b0}}, rel_bit(op_q, fin_lt, fin_eq)};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          k_d = k_q - KW'(1);
        end
`endif
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset discards any in-flight compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      op_q        <= 3'b000;
      k_q         <= {KW{1'b0}};
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
`ifndef CMP_EARLY_EXIT_EN
      found_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      k_q         <= k_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
`ifndef CMP_EARLY_EXIT_EN
      found_q     <= found_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cmp_iter.sv
// Self-checking bench for cmp_iter (WIDTH=32, CHUNK=8) with a result/latency
// scoreboard. Latency is counted in rising edges after the accept edge until
// out_valid is seen high; an illegal op is valid right after the accept edge.
module tb_cmp_iter;

  localparam int W = 32;
`ifdef CMP_EARLY_EXIT_EN
  localparam int LT_LAT = 1;
`else
  localparam int LT_LAT = 4;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    op = 3'b000;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic          busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    string        name;
  } exp_t;
  exp_t sb_q[$];

  cmp_iter #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Present one request, wait for the accept edge, then count edges until out_valid.
  task automatic do_req(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [2:0] opi,
                        output logic [W-1:0] res, output int lat);
    @(negedge clk);
    a = ai; b = bi; op = opi; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
  endtask

  // Pop the scoreboard entry and compare against what the DUT produced.
  task automatic check_out(input logic [W-1:0] res, input int lat);
    exp_t e;
    e = sb_q.pop_front();
    total++;
    if (res !== e.res) begin
      bad++;
      $display("FAIL %s_result: got %h expected %h", e.name, res, e.res);
    end
    total++;
    if (lat !== e.lat) begin
      bad++;
      $display("FAIL %s_latency: got %0d expected %0d", e.name, lat, e.lat);
    end
    // let the handshake complete (out_ready is high here)
    @(posedge clk);
    #1;
  endtask

  task automatic run_case(input string nm, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic [2:0] opi, input logic [W-1:0] er, input int el);
    logic [W-1:0] r;
    int l;
    sb_q.push_back('{res: er, lat: el, name: nm});
    do_req(ai, bi, opi, r, l);
    check_out(r, l);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, busy, result} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b v=%b busy=%b res=%h expected 1 0 0 0",
               in_ready, out_valid, busy, result);
    end
  endtask

  task automatic test_eq();
    run_case("eq_equal", 32'h12345678, 32'h12345678, 3'b000, 32'd1, 4);
    run_case("eq_msb_diff", 32'h92345678, 32'h12345678, 3'b000, 32'd0, LT_LAT);
  endtask

  task automatic test_lt();
    run_case("lt_signed", 32'hFFFFFFFF, 32'h00000001, 3'b001, 32'd1, LT_LAT);
    run_case("ltu", 32'hFFFFFFFF, 32'h00000001, 3'b101, 32'd0, LT_LAT);
  endtask

  task automatic test_le();
    run_case("le_equal_min", 32'h80000000, 32'h80000000, 3'b010, 32'd1, 4);
    run_case("leu_lsb", 32'd5, 32'd3, 3'b110, 32'd0, 4);
  endtask

  task automatic test_illegal();
    run_case("illegal_111", 32'd1, 32'd1, 3'b111, 32'd0, 0);
    run_case("illegal_011", 32'd1, 32'd2, 3'b011, 32'd0, 0);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r;
    int l;
    out_ready = 1'b0;
    sb_q.push_back('{res: 32'd0, lat: 4, name: "bp"});
    do_req(32'd7, 32'd9, 3'b000, r, l);
    // competing request presented while the result is stalled
    a = 32'd1; b = 32'd1; op = 3'b000; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({out_valid, in_ready, busy, result} !== {1'b1, 1'b0, 1'b1, 32'd0}) begin
        bad++;
        $display("FAIL bp_stall%0d: got v=%b rdy=%b busy=%b res=%h expected 1 0 1 0",
                 i, out_valid, in_ready, busy, result);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_out(r, l);
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL bp_release: got rdy=%b v=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
    end
    @(posedge clk);
    #1;
    total++;
    if ({busy, out_valid} !== 2'b00) begin
      bad++;
      $display("FAIL bp_no_accept: got busy=%b v=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a = 32'hCAFEF00D; b = 32'hCAFEF00D; op = 3'b000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, busy, result, in_ready} !== {1'b0, 1'b0, 32'd0, 1'b1}) begin
      bad++;
      $display("FAIL mid_async_clear: got v=%b busy=%b res=%h rdy=%b expected 0 0 0 1",
               out_valid, busy, result, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_case("post_reset_lt", 32'd2, 32'd3, 3'b001, 32'd1, 4);
  endtask

  // Bound the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_eq();
    test_lt();
    test_le();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    total++;
    if (sb_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
